// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU front end.
//   IMEM_AW / INSTR_W : instruction-memory address width and instruction width
//   INSTR_NOP         : encoding of the no-op instruction word
//   opcode_t          : 4-bit opcode held in instruction bits [31:28]
//   fetch_entry_t     : {pc, instr} record passed from fetch to decode
package cpu_pkg;

    localparam int unsigned IMEM_AW = 8;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_INC  = 4'h5,
        OP_NEG  = 4'h6,
        OP_SUB  = 4'h7,
        OP_J    = 4'h8,
        OP_BRZ  = 4'h9,
        OP_JM   = 4'hA,
        OP_BRN  = 4'hB,
        OP_LD   = 4'hE,
        OP_LDPC = 4'hF
    } opcode_t;

    typedef struct packed {
        logic [IMEM_AW-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic opcode_t instr_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_t'(instr[31:28]);
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry skid buffer of {pc, instr} between fetch and decode.
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush              : discard all entries (wins over push/pop)
//   push, push_pc/instr: write one entry
//   pop                : remove head entry (ignored when empty)
//   count              : number of buffered entries (0..2)
//   head_valid/pc/instr: head entry, driven straight from flops
// The producer must never push into a full FIFO without popping.
module fetch_skid_fifo #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [AW-1:0] push_pc,
    input  logic [DW-1:0] push_instr,
    input  logic          pop,
    output logic [1:0]    count,
    output logic          head_valid,
    output logic [AW-1:0] head_pc,
    output logic [DW-1:0] head_instr
);

    logic [1:0]    count_q, count_d;
    logic [AW-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
    logic [DW-1:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;

    // Head is a dedicated register so the outputs never pass through a mux
    // from the write data; the tail slot shifts forward on pop.
    always_comb begin
        count_d      = count_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_instr_d = tail_instr_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push) begin
                        head_pc_d    = push_pc;
                        head_instr_d = push_instr;
                        count_d      = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_pc_d    = push_pc;
                        head_instr_d = push_instr;
                    end else if (push) begin
                        tail_pc_d    = push_pc;
                        tail_instr_d = push_instr;
                        count_d      = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_pc_d    = tail_pc_q;
                        head_instr_d = tail_instr_q;
                        if (push) begin
                            tail_pc_d    = push_pc;
                            tail_instr_d = push_instr;
                        end else begin
                            count_d = 2'd1;
                        end
                    end
                end
                default: count_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_instr_q <= '0;
        end else begin
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_instr_q <= tail_instr_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_pc    = head_pc_q;
    assign head_instr = head_instr_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end. Owns the PC, drives the
// instruction memory (1-cycle registered read), buffers returning words in a
// 2-entry skid FIFO and presents them to decode over valid/ready.
//   clk, rst_n             : clock, asynchronous active-low reset
//   imem_addr / imem_data  : instruction memory address out, read data in
//   redirect_valid/_target : taken branch/jump from execute (highest priority)
//   if_valid/if_ready      : handshake to decode
//   if_instr / if_pc       : delivered instruction and its address
// Build option: define IFETCH_NOP_SQUASH_EN to drop all-zero (NOP) words at
// capture instead of delivering them.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    import cpu_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic       pop;
    logic       capture_keep;
    logic       push;
    logic       issue;
    logic [1:0] fifo_count;
    logic [2:0] occupancy;

    assign pop = if_valid & if_ready;

`ifdef IFETCH_NOP_SQUASH_EN
    assign capture_keep = inflight_q & (imem_data != INSTR_W'(INSTR_NOP));
`else
    assign capture_keep = inflight_q;
`endif

    // Returning words are discarded on redirect (the FIFO flushes as well).
    assign push = capture_keep & ~redirect_valid;

    // Entries the FIFO will hold after this edge; a new issue lands one cycle
    // later, so it is allowed only while that stays below two. A squashed NOP
    // does not count, which releases its slot immediately.
    assign occupancy = 3'(fifo_count) + 3'(capture_keep) - 3'(pop);
    assign issue     = (occupancy < 3'd2);

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        imem_addr     = pc_q;
        if (redirect_valid) begin
            imem_addr     = redirect_target;
            pc_d          = redirect_target + ADDR_W'(1);
            inflight_pc_d = redirect_target;
            inflight_d    = 1'b1;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(1);
            inflight_pc_d = pc_q;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= ADDR_W'(RESET_PC);
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_skid_fifo #(
        .AW(ADDR_W),
        .DW(INSTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_pc    (inflight_pc_q),
        .push_instr (imem_data),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed, table-driven bench for instr_fetch_unit with
// a registered-read instruction memory model holding a 33-word program.
module tb_instr_fetch_unit;

    import cpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;

    int checks;
    int errors;

    logic [31:0] mem [0:255];

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (32),
        .RESET_PC (0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    localparam logic [31:0] W0  = 32'hF040_0100;
    localparam logic [31:0] W4  = 32'h5081_0000;
    localparam logic [31:0] W5  = 32'h6080_0000;
    localparam logic [31:0] W6  = 32'h9000_0A00;
    localparam logic [31:0] W10 = 32'h7040_0100;
    localparam logic [31:0] W13 = 32'h8000_000E;
    localparam logic [31:0] W14 = 32'h3001_0400;
    localparam logic [31:0] W15 = 32'hE101_0000;
    localparam logic [31:0] W16 = 32'h5100_0010;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [7:0]  tgt;
        logic        exp_v;
        logic [7:0]  exp_pc;
        logic [31:0] exp_instr;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t tbl [29];

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [7:0] tgt,
                                input logic v, input logic [7:0] pc, input logic [31:0] ins,
                                input logic [7:0] addr);
        vec_t r;
        r.rdy = rdy; r.redir = redir; r.tgt = tgt;
        r.exp_v = v; r.exp_pc = pc; r.exp_instr = ins; r.exp_addr = addr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: checks registered outputs, then drives this
    // cycle's inputs and checks the combinational memory address.
    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            chk($sformatf("row%0d valid", i), 32'(if_valid), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk($sformatf("row%0d pc", i), 32'(if_pc), 32'(tbl[i].exp_pc));
                chk($sformatf("row%0d instr", i), if_instr, tbl[i].exp_instr);
            end
            if_ready        = tbl[i].rdy;
            redirect_valid  = tbl[i].redir;
            redirect_target = tbl[i].tgt;
            #1;
            chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(tbl[i].exp_addr));
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = W0;  mem[4] = W4;  mem[5] = W5;  mem[6] = W6;
        mem[10] = W10; mem[13] = W13; mem[14] = W14; mem[15] = W15;
        for (int i = 16; i <= 32; i++) mem[i] = 32'h5100_0000 | 32'(i);

        //            rdy redir tgt   v  pc     instr  addr
        tbl[0]  = mk(1, 0, 8'd0,   0, 8'd0,   '0,  8'd0);
        tbl[1]  = mk(1, 0, 8'd0,   0, 8'd0,   '0,  8'd1);
        tbl[2]  = mk(1, 0, 8'd0,   1, 8'd0,   W0,  8'd2);
        tbl[3]  = mk(1, 0, 8'd0,   1, 8'd1,   '0,  8'd3);
        tbl[4]  = mk(1, 0, 8'd0,   1, 8'd2,   '0,  8'd4);
        tbl[5]  = mk(1, 0, 8'd0,   1, 8'd3,   '0,  8'd5);
        tbl[6]  = mk(0, 0, 8'd0,   1, 8'd4,   W4,  8'd6);
        tbl[7]  = mk(0, 0, 8'd0,   1, 8'd4,   W4,  8'd6);
        tbl[8]  = mk(0, 0, 8'd0,   1, 8'd4,   W4,  8'd6);
        tbl[9]  = mk(0, 0, 8'd0,   1, 8'd4,   W4,  8'd6);
        tbl[10] = mk(0, 0, 8'd0,   1, 8'd4,   W4,  8'd6);
        tbl[11] = mk(1, 0, 8'd0,   1, 8'd4,   W4,  8'd6);
        tbl[12] = mk(1, 0, 8'd0,   1, 8'd5,   W5,  8'd7);
        tbl[13] = mk(1, 0, 8'd0,   1, 8'd6,   W6,  8'd8);
        tbl[14] = mk(1, 0, 8'd0,   1, 8'd7,   '0,  8'd9);
        tbl[15] = mk(1, 0, 8'd0,   1, 8'd8,   '0,  8'd10);
        tbl[16] = mk(1, 0, 8'd0,   1, 8'd9,   '0,  8'd11);
        tbl[17] = mk(1, 0, 8'd0,   1, 8'd10,  W10, 8'd12);
        tbl[18] = mk(0, 0, 8'd0,   1, 8'd11,  '0,  8'd13);
        tbl[19] = mk(0, 1, 8'd14,  1, 8'd11,  '0,  8'd14);
        tbl[20] = mk(1, 0, 8'd0,   0, 8'd0,   '0,  8'd15);
        tbl[21] = mk(1, 0, 8'd0,   1, 8'd14,  W14, 8'd16);
        tbl[22] = mk(1, 0, 8'd0,   1, 8'd15,  W15, 8'd17);
        tbl[23] = mk(1, 1, 8'd255, 1, 8'd16,  W16, 8'd255);
        tbl[24] = mk(1, 0, 8'd0,   0, 8'd0,   '0,  8'd0);
        tbl[25] = mk(1, 0, 8'd0,   1, 8'd255, '0,  8'd1);
        tbl[26] = mk(1, 0, 8'd0,   1, 8'd0,   W0,  8'd2);
        tbl[27] = mk(0, 0, 8'd0,   1, 8'd1,   '0,  8'd3);
        tbl[28] = mk(0, 0, 8'd0,   1, 8'd1,   '0,  8'd3);

        rst_n = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        repeat (3) @(negedge clk);
        chk("reset valid", 32'(if_valid), 32'd0);
        chk("reset pc", 32'(if_pc), 32'd0);
        chk("reset instr", if_instr, 32'd0);
        chk("reset imem_addr", 32'(imem_addr), 32'd0);
        rst_n = 1'b1;

`ifndef IFETCH_NOP_SQUASH_EN
        // Startup, stall, redirect with full FIFO, wrap at 255, full again.
        run_rows(0, 28);

        // Asynchronous reset mid-cycle with the FIFO full.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset valid", 32'(if_valid), 32'd0);
        chk("midreset pc", 32'(if_pc), 32'd0);
        chk("midreset instr", if_instr, 32'd0);
        chk("midreset imem_addr", 32'(imem_addr), 32'd0);
        if_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("inreset valid", 32'(if_valid), 32'd0);
        rst_n = 1'b1;
        run_rows(0, 4);
`else
        begin
            fetch_entry_t got [$];
            logic [7:0] exp_pcs [8];
            exp_pcs = '{8'd0, 8'd4, 8'd5, 8'd6, 8'd10, 8'd13, 8'd14, 8'd15};
            if_ready = 1'b1;
            for (int c = 0; c < 40; c++) begin
                if (if_valid && if_ready) begin
                    got.push_back('{pc: if_pc, instr: if_instr});
                    chk("squash nonzero", 32'(if_instr != INSTR_NOP), 32'd1);
                end
                @(negedge clk);
            end
            chk("squash count enough", 32'(got.size() >= 8), 32'd1);
            for (int k = 0; k < 8; k++) begin
                if (k < got.size())
                    chk($sformatf("squash pc%0d", k), 32'(got[k].pc), 32'(exp_pcs[k]));
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
